// File: rtl/an_cba_pkg.sv
// Shared constants and helpers for the carry-bypass adder.
// NBLK is always derived here so every user sizes its carry vector the same way.
package an_cba_pkg;

    localparam int CBA_WIDTH = 8;
    localparam int CBA_BLOCK = 4;

    function automatic int cba_nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit cba_cfg_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/an_cba_cba_block.sv
// One carry-bypass block: ripple adder plus block-propagate skip mux on the carry-out.
module cba_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_blk,
    input  logic [BLOCK-1:0] b_blk,
    input  logic             cin,
    output logic [BLOCK-1:0] s_blk,
    output logic             cout
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             blk_p;

    assign p     = a_blk ^ b_blk;
    assign g     = a_blk & b_blk;
    assign blk_p = &p;

    always_comb begin
        c     = '0;
        s_blk = '0;
        c[0]  = cin;
        for (int i = 0; i < BLOCK; i++) begin
            s_blk[i] = p[i] ^ c[i];
            c[i+1]   = g[i] | (p[i] & c[i]);
        end
    end

    // Skip path: when every bit propagates, cin goes straight out without the ripple.
    assign cout = blk_p ? cin : c[BLOCK];

endmodule

// File: rtl/an_cba.sv
// Registered carry-skip adder: NBLK chained bypass blocks feeding an output register.
// carryout exposes every block's carry-out; the top bit is the final carry.
module an_cba
    import an_cba_pkg::*;
#(
    parameter int WIDTH = CBA_WIDTH,
    parameter int BLOCK = CBA_BLOCK
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                carryin,
    output logic [WIDTH-1:0]                    sum,
    output logic [cba_nblk(WIDTH, BLOCK)-1:0]   carryout
);

    localparam int NBLK = cba_nblk(WIDTH, BLOCK);

    if (!cba_cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
        $error("an_cba: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [WIDTH-1:0] sum_comb;
    logic [NBLK-1:0]  cvec;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        logic             cin_b;
        logic             cout_b;
        logic [BLOCK-1:0] s_b;

        if (i == 0) begin : g_first
            assign cin_b = carryin;
        end else begin : g_next
            assign cin_b = g_blk[i-1].cout_b;
        end

        cba_block #(.BLOCK(BLOCK)) u_blk (
            .a_blk (a[i*BLOCK +: BLOCK]),
            .b_blk (b[i*BLOCK +: BLOCK]),
            .cin   (cin_b),
            .s_blk (s_b),
            .cout  (cout_b)
        );

        assign sum_comb[i*BLOCK +: BLOCK] = s_b;
        assign cvec[i]                    = cout_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum      <= '0;
            carryout <= '0;
        end else begin
            sum      <= sum_comb;
            carryout <= cvec;
        end
    end

endmodule

// File: tb/tb_an_cba.sv
// Self-checking bench for an_cba at 8 and 16 bits against an arithmetic reference.
module tb_an_cba;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a8, b8;
    logic        cin8;
    logic [7:0]  sum8;
    logic [1:0]  co8;
    logic [15:0] a16, b16;
    logic        cin16;
    logic [15:0] sum16;
    logic [3:0]  co16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    an_cba #(.WIDTH(8), .BLOCK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carryin(cin8),
        .sum(sum8), .carryout(co8)
    );

    an_cba #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .carryin(cin16),
        .sum(sum16), .carryout(co16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Exact addition truncated to the operand width.
    function automatic longint unsigned ref_sum(input int w, input longint unsigned x,
                                                input longint unsigned y, input bit ci);
        longint unsigned m = (64'd1 << w) - 1;
        return ((x & m) + (y & m) + ci) & m;
    endfunction

    // Carry out of block i is bit BLOCK*(i+1) of the sum of the low BLOCK*(i+1) bits.
    function automatic longint unsigned ref_carry(input int w, input longint unsigned x,
                                                  input longint unsigned y, input bit ci);
        longint unsigned r = 0;
        for (int i = 0; i < w / 4; i++) begin
            int bits = 4 * (i + 1);
            longint unsigned m = (64'd1 << bits) - 1;
            longint unsigned t = (x & m) + (y & m) + ci;
            r |= ((t >> bits) & 64'd1) << i;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        a8 = x; b8 = y; cin8 = ci;
    endtask

    task automatic check8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci);
        chk({tag, "_sum"}, 64'(sum8), ref_sum(8, x, y, ci));
        chk({tag, "_co"},  64'(co8),  ref_carry(8, x, y, ci));
    endtask

    logic [7:0] dx [6] = '{8'h0F, 8'h0F, 8'hFF, 8'h08, 8'h80, 8'h12};
    logic [7:0] dy [6] = '{8'hF0, 8'hF0, 8'h01, 8'h08, 8'h80, 8'h34};
    logic       dc [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    logic [7:0] es [6] = '{8'h00, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h46};
    logic [1:0] ec [6] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};

    initial begin
        rst_n = 1'b0;
        drive8(8'hFF, 8'hFF, 1'b1);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;

        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_sum8", 64'(sum8), 64'h0);
            chk("rst_co8",  64'(co8),  64'h0);
            chk("rst_sum16", 64'(sum16), 64'h0);
            chk("rst_co16",  64'(co16),  64'h0);
        end

        rst_n = 1'b1;
        drive8(8'h00, 8'h00, 1'b0);
        a16 = '0; b16 = '0; cin16 = 1'b0;
        step();
        chk("rel_sum8", 64'(sum8), 64'h0);
        chk("rel_co8",  64'(co8),  64'h0);

        // Directed vectors, back-to-back, against hand-computed constants.
        for (int k = 0; k < 6; k++) begin
            drive8(dx[k], dy[k], dc[k]);
            step();
            chk($sformatf("dir%0d_sum", k), 64'(sum8), 64'(es[k]));
            chk($sformatf("dir%0d_co", k),  64'(co8),  64'(ec[k]));
        end

        // Outputs must hold while inputs move mid-cycle.
        drive8(8'hA5, 8'h5A, 1'b1);
        #3;
        chk("hold_sum", 64'(sum8), 64'h46);
        chk("hold_co",  64'(co8),  64'h0);

        // Reset mid-stream discards the operation presented on that edge.
        step();
        check8("pre_rst", 8'hA5, 8'h5A, 1'b1);
        rst_n = 1'b0;
        drive8(8'hFF, 8'h01, 1'b1);
        step();
        chk("mid_rst_sum", 64'(sum8), 64'h0);
        chk("mid_rst_co",  64'(co8),  64'h0);
        rst_n = 1'b1;

        for (int n = 0; n < 10000; n++) begin
            logic [7:0]  x8, y8;
            logic [15:0] x16, y16;
            logic        c8, c16;
            x8  = 8'($urandom);  y8  = 8'($urandom);  c8  = 1'($urandom);
            x16 = 16'($urandom); y16 = 16'($urandom); c16 = 1'($urandom);
            if (n % 16 == 0) begin
                x16 = 16'hFFFF ^ y16;
                y8  = 8'hFF ^ x8;
            end
            drive8(x8, y8, c8);
            a16 = x16; b16 = y16; cin16 = c16;
            step();
            check8("rnd8", x8, y8, c8);
            chk("rnd16_sum", 64'(sum16), ref_sum(16, x16, y16, c16));
            chk("rnd16_co",  64'(co16),  ref_carry(16, x16, y16, c16));
            chk("rnd16_final", 64'(co16[3]), (64'(x16) + 64'(y16) + 64'(c16)) >> 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/an_cba.md
# an_cba

Registered N-bit carry-bypass (carry-skip) adder, default 8 bits, split into 4-bit blocks. Each block ripples internally and skips its carry-in straight to its carry-out when every bit in the block propagates. The block exposes the carry-out of every block. It is a datapath leaf used wherever a low-latency, single-cycle registered add with per-block carry visibility is needed.

## Interface
- WIDTH, 8: operand and sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4: bits per bypass block.
- NBLK, WIDTH/BLOCK (derived, 2 by default): number of blocks and the width of carryout.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- carryin  input  1  carry into block 0.
- sum  output  WIDTH  registered (a + b + carryin) mod 2^WIDTH.
- carryout  output  NBLK  registered carry-out of each block; bit i belongs to block i; bit NBLK-1 is the adder's final carry.

## Operation
- Block i covers bits [i*BLOCK +: BLOCK].
  - Its carry-in is carryin for i=0, otherwise the carry-out of block i-1.
- Per bit: p = a^b, g = a&b, s = p^c, c_next = g | (p&c).
- Block propagate P_i = AND of all p bits in the block.
- Block carry-out = P_i ? block carry-in : ripple carry-out of the block's top bit.
  - Both paths are logically equal; the mux is the required bypass structure and must not be optimised into a plain ripple in source.
- Each carryout[i] carries the block's carry-out, not its carry-in.
- Result is exact unsigned addition. There is no overflow flag; signed interpretation is the user's responsibility.
- Combinational operands feed an output register:
  - sum_q <= sum_comb
  - carryout_q <= carry vector

## Timing
- Latency is 1 cycle. Inputs present before rising edge k appear on sum/carryout after edge k.
- Throughput is one add per cycle. There is no handshake, valid, or stall.
- When rst_n=0 at a rising edge:
  - sum <= 0, carryout <= 0, regardless of inputs.
  - Reset has priority over any in-flight add; the operation presented in that cycle is discarded.
- First valid result follows the first edge with rst_n=1.
- Outputs hold their value between edges. Inputs changing mid-cycle have no effect until the next edge.
- The combinational path is at most BLOCK ripple stages plus NBLK bypass muxes, and must close at the system clock.

## Structure
- A shared package holds:
  - default WIDTH/BLOCK constants
  - a function computing NBLK
  - an elaboration-time check that WIDTH % BLOCK == 0
- Sub-module cba_block (BLOCK-bit ripple with propagate-AND and bypass mux) has:
  - inputs a_blk, b_blk, cin
  - outputs s_blk, cout
- an_cba instantiates NBLK cba_block instances via generate, chains their carries, and registers the outputs.

## Test plan
- Reset: drive rst_n=0 with a=0xFF, b=0xFF, carryin=1 for 2 cycles -> sum=0x00, carryout=2'b00. Deassert with a=0, b=0, carryin=0 -> sum=0x00, carryout=00 one cycle later.
- Full bypass: a=0x0F, b=0xF0, carryin=1 -> sum=0x00, carryout=2'b11. Same operands with carryin=0 -> sum=0xFF, carryout=2'b00.
- Ripple through both blocks: a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=2'b11.
- Per-block carries:
  - a=0x08, b=0x08 -> sum=0x10, carryout=2'b01.
  - a=0x80, b=0x80 -> sum=0x00, carryout=2'b10.
  - a=0x12, b=0x34 -> sum=0x46, carryout=2'b00.
- Back-to-back and reset mid-stream: issue the three adds above on consecutive cycles; each result appears exactly 1 cycle after its operands. Then assert rst_n=0 on the next edge -> outputs 0 on that edge.
- Random: 10,000 random a, b, carryin vs a reference model of {carry, sum} = a + b + carryin, plus per-nibble carries, checked at 1-cycle latency. Also repeat with WIDTH=16, BLOCK=4 (NBLK=4).
